gate_vector_player: RTL

- Synthesizable stimulus/response engine for the 2x8-bit to 1-bit comparison gate block (complex_gates).
- Drives the gate's x/y inputs from an internal vector table, samples the gate's out, and checks it against the expected bit.
- Reports pass/fail and error counts, so the gate can be checked on hardware (board LEDs) as well as in simulation.
- Sits beside complex_gates in the top level: our outputs feed its inputs, its output feeds us.

---
 rtl/gate_vec_pkg.sv | 21 ++
 rtl/gate_vec_rom.sv | 18 +
 rtl/gate_vector_player.sv | 112 +++++++++++
 3 files changed

// File: rtl/gate_vec_pkg.sv
// Shared types and the default stimulus table for the gate vector player.
// Table entries 8..15 are zero vectors expecting 0.
package gate_vec_pkg;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

  localparam int VEC_DEPTH = 16;
  localparam int TBL_W     = 8;

  // Packed tables are written MSB first: index 15 leftmost, index 0 rightmost.
  localparam logic [VEC_DEPTH-1:0][TBL_W-1:0] DEF_X = {
    {8{8'h00}},
    8'hFF, 8'hE4, 8'hF4, 8'hE4, 8'hE4, 8'hE5, 8'h67, 8'h67
  };
  localparam logic [VEC_DEPTH-1:0][TBL_W-1:0] DEF_Y = {
    {8{8'h00}},
    8'hFF, 8'hFF, 8'hDF, 8'hDF, 8'h1F, 8'h1F, 8'h1F, 8'h1B
  };
  localparam logic [VEC_DEPTH-1:0] DEF_EXP = 16'b0000_0000_1110_0110;

endpackage

// File: rtl/gate_vec_rom.sv
// Combinational vector lookup: index to {x, y, expected bit}.
module gate_vec_rom
  import gate_vec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic              exp_bit
);

  assign x       = DATA_W'(DEF_X[idx]);
  assign y       = DATA_W'(DEF_Y[idx]);
  assign exp_bit = DEF_EXP[idx];

endmodule

// File: rtl/gate_vector_player.sv
// Plays the vector table into the comparison gate, samples its output after
// a settle window and keeps a pass flag, error count and first-fail index.
module gate_vector_player
  import gate_vec_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_VEC    = 8,
  parameter int SETTLE_CYC = 2,
  parameter int IDX_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W:0]    err_count,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [IDX_W-1:0]  cur_idx
);

  localparam int               EW          = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t              state, state_nxt;
  logic [3:0]          settle_cnt;
  logic [DATA_W-1:0]   rom_x, rom_y;
  logic                rom_exp;
  logic                mismatch;
  logic [IDX_W:0]      err_nxt;

  gate_vec_rom #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_rom (
    .idx     (cur_idx),
    .x       (rom_x),
    .y       (rom_y),
    .exp_bit (rom_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (cur_idx == LAST_IDX) ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating error count; next value also feeds pass so the last sample counts.
  always_comb begin
    mismatch = (state == SAMPLE) && (dut_out != rom_exp);
    err_nxt  = err_count;
    if (mismatch && (err_count != '1)) err_nxt = err_count + EW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_idx   <= '0;
      cur_idx    <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          x <= '0;
          y <= '0;
          if (start) begin
            err_count <= '0;
            fail_idx  <= '0;
            cur_idx   <= '0;
            pass      <= 1'b0;
          end
        end
        APPLY: begin
          x          <= rom_x;
          y          <= rom_y;
          settle_cnt <= '0;
        end
        SETTLE: settle_cnt <= settle_cnt + 4'd1;
        SAMPLE: begin
          err_count <= err_nxt;
          if (mismatch && (err_count == '0)) fail_idx <= cur_idx;
          if (cur_idx == LAST_IDX) pass <= (err_nxt == '0);
          else                     cur_idx <= cur_idx + IDX_W'(1);
        end
        DONE: begin
          x <= '0;
          y <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

endmodule
